// File: rtl/quad_enc_module_if.sv
// -----------------------------------------------------------------------------
// quad_enc_module_if
// Avalon-MM slave bus bundle for the quadrature encoder block.
//   chipselect  - slave select
//   read        - read strobe (readdata valid one clock later)
//   write       - write strobe
//   address     - 4-bit word address
//   writedata   - 32-bit write data
//   readdata    - 32-bit registered read data
// Modports: master (bus host / testbench), slave (quad_enc_module).
// -----------------------------------------------------------------------------
interface quad_enc_module_if;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output read,
        output write,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/quad_enc_module.sv
// -----------------------------------------------------------------------------
// quad_enc_module
// Three-axis quadrature encoder counter with Avalon-MM register access.
// Each of the nine encoder pins (A/B/Z per axis) is synchronized, debounced by
// a FILT_LEN-sample filter and decoded in 4x mode into a 32-bit signed count.
// Index (Z) rising edges can latch and/or clear the count.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - Avalon-MM slave (quad_enc_module_if.slave)
//   ienc_a   - channel A, one bit per axis (asynchronous)
//   ienc_b   - channel B, one bit per axis (asynchronous)
//   ienc_z   - index, one bit per axis (asynchronous)
//
// Register map (word address):
//   0x0-0x2 count axis 0-2 (RW)      0x3-0x5 index latch axis 0-2 (RO)
//   0x6 control: [2:0] enable, [5:3] latch-on-index, [8:6] clear-on-index
//   0x7 status : [2:0] index flags, [5:3] error flags (write-1-to-clear)
//   0x8 filtered inputs {Z[8:6], B[5:3], A[2:0]} (RO)
// -----------------------------------------------------------------------------
module quad_enc_module #(
    parameter int FILT_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    quad_enc_module_if.slave       bus,
    input  logic [2:0]             ienc_a,
    input  logic [2:0]             ienc_b,
    input  logic [2:0]             ienc_z
);

    localparam int FCW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

    logic [8:0]           w_pins;
    logic [8:0]           r_sync1;
    logic [8:0]           r_sync2;
    logic [8:0]           r_filt;
    logic [8:0]           r_filt_d;
    logic [FCW-1:0]       r_fcnt [9];

    logic signed [31:0]   r_count [3];
    logic signed [31:0]   r_index [3];
    logic [8:0]           r_ctrl;
    logic [2:0]           r_iflag;
    logic [2:0]           r_err;
    logic [31:0]          r_readdata;

    logic [2:0][1:0]      w_step;
    logic [2:0]           w_inc;
    logic [2:0]           w_dec;
    logic [2:0]           w_ill;
    logic [2:0]           w_zrise;
    logic [2:0]           w_cnt_wr;
    logic [2:0]           w_iflag_clr;
    logic [2:0]           w_err_clr;
    logic [2:0]           w_iflag_set;
    logic                 w_wr;
    logic                 w_rd;
    logic [31:0]          w_rdata;

    assign w_pins = {ienc_z, ienc_b, ienc_a};
    assign w_wr   = bus.chipselect && bus.write;
    assign w_rd   = bus.chipselect && bus.read && !bus.write;

    // ---- stage: two-flop synchronizer ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
        end
    end

    // ---- stage: run-length filter, then one-clock history for edge detect ----
    // The counter tracks how many consecutive samples disagreed with the
    // filtered level; the level flips on the FILT_LEN-th disagreeing sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt   <= '0;
            r_filt_d <= '0;
            for (int i = 0; i < 9; i++) r_fcnt[i] <= '0;
        end else begin
            r_filt_d <= r_filt;
            for (int i = 0; i < 9; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FCW'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    // Phase index {B, A^B} walks 0,1,2,3 for the forward sequence
    // 00->10->11->01, so the modulo-4 difference gives +1 (1), -1 (3) or
    // an illegal double change (2). Disabled axes produce no events but the
    // history register above keeps tracking, so enabling is glitch-free.
    always_comb begin
        w_step      = '0;
        w_inc       = '0;
        w_dec       = '0;
        w_ill       = '0;
        w_zrise     = '0;
        w_cnt_wr    = '0;
        w_iflag_set = '0;
        for (int ax = 0; ax < 3; ax++) begin
            w_step[ax]      = {r_filt[3+ax], r_filt[ax] ^ r_filt[3+ax]}
                            - {r_filt_d[3+ax], r_filt_d[ax] ^ r_filt_d[3+ax]};
            w_inc[ax]       = r_ctrl[ax] && (w_step[ax] == 2'd1);
            w_dec[ax]       = r_ctrl[ax] && (w_step[ax] == 2'd3);
            w_ill[ax]       = r_ctrl[ax] && (w_step[ax] == 2'd2);
            w_zrise[ax]     = r_ctrl[ax] && r_filt[6+ax] && !r_filt_d[6+ax];
            w_iflag_set[ax] = w_zrise[ax] && r_ctrl[3+ax];
            w_cnt_wr[ax]    = w_wr && (bus.address == 4'(ax));
        end
        w_iflag_clr = (w_wr && bus.address == 4'd7) ? bus.writedata[2:0] : 3'b000;
        w_err_clr   = (w_wr && bus.address == 4'd7) ? bus.writedata[5:3] : 3'b000;
    end

    // ---- stage: counters, index latches, control and status ----
    // Count priority: bus write, then index clear, then quadrature step.
    // The index latch captures the count as it was before this edge's update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ax = 0; ax < 3; ax++) begin
                r_count[ax] <= '0;
                r_index[ax] <= '0;
            end
            r_ctrl  <= '0;
            r_iflag <= '0;
            r_err   <= '0;
        end else begin
            for (int ax = 0; ax < 3; ax++) begin
                if (w_cnt_wr[ax]) begin
                    r_count[ax] <= $signed(bus.writedata);
                end else if (w_zrise[ax] && r_ctrl[6+ax]) begin
                    r_count[ax] <= '0;
                end else if (w_inc[ax]) begin
                    r_count[ax] <= r_count[ax] + 32'sd1;
                end else if (w_dec[ax]) begin
                    r_count[ax] <= r_count[ax] - 32'sd1;
                end
                if (w_iflag_set[ax]) begin
                    r_index[ax] <= r_count[ax];
                end
            end
            if (w_wr && bus.address == 4'd6) begin
                r_ctrl <= bus.writedata[8:0];
            end
            // A flag being set this cycle wins over its write-1-to-clear.
            r_iflag <= w_iflag_set | (r_iflag & ~w_iflag_clr);
            r_err   <= w_ill       | (r_err   & ~w_err_clr);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            4'd0:    w_rdata = r_count[0];
            4'd1:    w_rdata = r_count[1];
            4'd2:    w_rdata = r_count[2];
            4'd3:    w_rdata = r_index[0];
            4'd4:    w_rdata = r_index[1];
            4'd5:    w_rdata = r_index[2];
            4'd6:    w_rdata = {23'd0, r_ctrl};
            4'd7:    w_rdata = {26'd0, r_err, r_iflag};
            4'd8:    w_rdata = {23'd0, r_filt};
            default: w_rdata = '0;
        endcase
    end

    // ---- stage: registered read data ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_quad_enc_module.sv
// -----------------------------------------------------------------------------
// tb_quad_enc_module
// Directed bench for quad_enc_module. A register-level model of the encoder
// (per-axis phase, count, index latch, control and flags) predicts every
// register read; a single compare process checks readdata one clock after
// each read strobe. Literal expectations pin the model at key points.
// -----------------------------------------------------------------------------
module tb_quad_enc_module;

    localparam int FILT_LEN = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] pa = '0;
    logic [2:0] pb = '0;
    logic [2:0] pz = '0;

    always #10 clk = ~clk;

    quad_enc_module_if bus();

    quad_enc_module #(.FILT_LEN(FILT_LEN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .ienc_a  (pa),
        .ienc_b  (pb),
        .ienc_z  (pz)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    logic [31:0] m_cnt [3];
    logic [31:0] m_idx [3];
    logic [8:0]  m_ctrl;
    logic [2:0]  m_iflag;
    logic [2:0]  m_eflag;
    int          m_phase [3];

    logic [31:0] exp_q [$];
    string       name_q [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] e);
        n_checks++;
        if (got !== e) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, e);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = '0;
            m_idx[i] = '0;
        end
        m_ctrl  = '0;
        m_iflag = '0;
        m_eflag = '0;
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0, 1, 2: return m_cnt[a];
            3, 4, 5: return m_idx[a-3];
            6:       return {23'd0, m_ctrl};
            7:       return {26'd0, m_eflag, m_iflag};
            8:       return {23'd0, pz, pb, pa};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_write(input int a, input logic [31:0] d);
        case (a)
            0, 1, 2: m_cnt[a] = d;
            6:       m_ctrl = d[8:0];
            7: begin
                m_iflag = m_iflag & ~d[2:0];
                m_eflag = m_eflag & ~d[5:3];
            end
            default: ;
        endcase
    endtask

    // Compare process: readdata is checked on the falling edge after a read.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.chipselect && bus.read && !bus.write) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_read: got 0x%08h required no read", bus.readdata);
                end else begin
                    chk(name_q.pop_front(), bus.readdata, exp_q.pop_front());
                end
            end
        end
    end

    // Bus helpers: *_at variants assume the caller is 1 ns after a rising edge.
    task automatic rd_at(input int a, input logic [31:0] e, input string nm);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write      = 1'b0;
        bus.address    = 4'(a);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
    endtask

    task automatic rd(input int a, input string nm);
        @(posedge clk);
        #1;
        rd_at(a, m_read(a), nm);
    endtask

    task automatic rd_lit(input int a, input logic [31:0] e, input string nm);
        @(posedge clk);
        #1;
        chk({"model_", nm}, m_read(a), e);
        rd_at(a, e, nm);
    endtask

    task automatic wr_at(input int a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.read       = 1'b0;
        bus.address    = 4'(a);
        bus.writedata  = d;
        @(posedge clk);
        m_write(a, d);
        #1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        @(posedge clk);
        #1;
        wr_at(a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Encoder stimulus: phase 0..3 maps to (A,B) = 00,10,11,01.
    task automatic drive_step(input int ax, input int dir);
        m_phase[ax] = (m_phase[ax] + dir) & 3;
        pa[ax] = (m_phase[ax] == 1) || (m_phase[ax] == 2);
        pb[ax] = (m_phase[ax] == 2) || (m_phase[ax] == 3);
        if (m_ctrl[ax]) m_cnt[ax] = m_cnt[ax] + 32'(dir);
    endtask

    task automatic step(input int ax, input int dir);
        drive_step(ax, dir);
        idle(20);
    endtask

    task automatic illegal(input int ax);
        m_phase[ax] = (m_phase[ax] + 2) & 3;
        pa[ax] = ~pa[ax];
        pb[ax] = ~pb[ax];
        if (m_ctrl[ax]) m_eflag[ax] = 1'b1;
        idle(20);
    endtask

    task automatic zpulse(input int ax);
        pz[ax] = 1'b1;
        if (m_ctrl[ax]) begin
            if (m_ctrl[3+ax]) begin
                m_idx[ax]   = m_cnt[ax];
                m_iflag[ax] = 1'b1;
            end
            if (m_ctrl[6+ax]) m_cnt[ax] = '0;
        end
        idle(20);
        pz[ax] = 1'b0;
        idle(20);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_cnt;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        for (int i = 0; i < 3; i++) m_phase[i] = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Reset state
        for (int a = 0; a < 9; a++) rd_lit(a, 32'd0, $sformatf("reset_reg%0d", a));

        // Forward / reverse counting on axis 0
        wr(6, 32'h1);
        rd_lit(6, 32'h1, "ctrl_en0");
        for (int i = 0; i < 8; i++) step(0, 1);
        rd_lit(0, 32'd8, "cnt0_fwd8");
        for (int i = 0; i < 8; i++) step(0, -1);
        rd_lit(0, 32'd0, "cnt0_rev8");

        // Wrap-around on axis 1
        wr(6, 32'h3);
        wr(1, 32'h7FFF_FFFF);
        step(1, 1);
        rd_lit(1, 32'h8000_0000, "cnt1_wrap_pos");
        wr(1, 32'h0);
        step(1, -1);
        rd_lit(1, 32'hFFFF_FFFF, "cnt1_wrap_neg");

        // Glitch shorter than the filter length on A of axis 0
        pa[0] = ~pa[0];
        idle(FILT_LEN - 1);
        pa[0] = ~pa[0];
        idle(20);
        rd_lit(0, 32'd0, "cnt0_glitch");
        rd_lit(8, 32'd0, "raw_glitch");

        // Disabled axis 2 holds; enabling it causes no spurious count
        step(2, 1);
        rd_lit(2, 32'd0, "cnt2_disabled");
        wr(6, 32'h7);
        idle(10);
        rd(2, "cnt2_enable");
        rd_lit(7, 32'd0, "status_enable");

        // Illegal double transition on axis 2
        illegal(2);
        rd_lit(2, 32'd0, "cnt2_illegal");
        rd_lit(7, 32'h20, "status_err2");
        rd_lit(8, 32'h20, "raw_after_illegal");
        wr(7, 32'h20);
        rd_lit(7, 32'd0, "status_w1c");

        // Latency: old value one clock before, new value exactly at the edge
        old_cnt = m_cnt[0];
        drive_step(0, 1);
        repeat (FILT_LEN + 2) @(posedge clk);
        #1;
        rd_at(0, old_cnt, "lat_before");
        rd_at(0, m_cnt[0], "lat_after");
        idle(20);
        rd_lit(0, 32'd1, "cnt0_lat");

        // Count write beats a same-cycle step
        drive_step(0, 1);
        repeat (FILT_LEN + 2) @(posedge clk);
        #1;
        wr_at(0, 32'd1234);
        idle(20);
        rd_lit(0, 32'd1234, "wr_prio");

        // Index latch + clear on axis 0; upper control bits read back 0
        wr(0, 32'd100);
        wr(6, 32'hFFFF_FE49);
        rd_lit(6, 32'h49, "ctrl_rb");
        zpulse(0);
        rd_lit(3, 32'd100, "index0");
        rd_lit(0, 32'd0, "cnt0_idx_clr");
        rd_lit(7, 32'h1, "status_idx0");
        rd(4, "index1_idle");

        // Asynchronous reset in the middle of a step sequence
        wr(6, 32'h1);
        wr(7, 32'h1);
        for (int i = 0; i < 5; i++) step(0, 1);
        rd_lit(0, 32'd5, "cnt0_pre_reset");
        drive_step(0, 1);
        idle(3);
        #3;
        reset_n = 1'b0;
        m_reset();
        idle(3);
        reset_n = 1'b1;
        idle(20);
        for (int a = 0; a < 8; a++) rd_lit(a, 32'd0, $sformatf("post_reset_reg%0d", a));
        rd(8, "post_reset_raw");

        idle(4);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL pending_reads: got %0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
